// File: rtl/ddr4_init_sequencer_pkg.sv
// Shared DDR4 init definitions: sequencer states, command encodings, MR issue order
// and default timing values used by the sequencer and the interface protocol checker.
package ddr_package;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_HIGH,
    ST_XPR_WAIT,
    ST_MRS_ISSUE,
    ST_MRS_WAIT,
    ST_ZQ_ISSUE,
    ST_ZQ_WAIT,
    ST_DONE
  } init_state_t;

  // Command pin bundle ordered {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}.
  typedef logic [4:0] ddr_cmd_t;

  localparam ddr_cmd_t CMD_DES  = 5'b11111;
  localparam ddr_cmd_t CMD_MRS  = 5'b01000;
  localparam ddr_cmd_t CMD_ZQCL = 5'b01110;

  localparam int NUM_MRS = 7;
  localparam logic [2:0] MR_ORDER [NUM_MRS] = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};

  localparam logic [13:0] ZQCL_ADDR = 14'h0400;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_T_RESET_L = 10;
  localparam int DEF_T_CKE_L   = 20;
  localparam int DEF_T_XPR     = 8;
  localparam int DEF_T_MRD     = 8;
  localparam int DEF_T_MOD     = 24;
  localparam int DEF_T_ZQ      = 32;

  // Mode register for a given position in the issue order; positions past the
  // last MRS map to MR0 so a finished sequence leaves the select at zero.
  function automatic logic [2:0] mr_at(input logic [2:0] idx);
    logic [2:0] mr;
    case (idx)
      3'd0:    mr = MR_ORDER[0];
      3'd1:    mr = MR_ORDER[1];
      3'd2:    mr = MR_ORDER[2];
      3'd3:    mr = MR_ORDER[3];
      3'd4:    mr = MR_ORDER[4];
      3'd5:    mr = MR_ORDER[5];
      3'd6:    mr = MR_ORDER[6];
      default: mr = 3'd0;
    endcase
    return mr;
  endfunction

endpackage

// File: rtl/ddr4_init_sequencer_timer.sv
// Loadable down-counter shared by the init sequencer and the refresh scheduler:
// load (delay-1) on entry to a timed phase, the phase ends when expired is high.
module init_delay_timer
  import ddr_package::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock_t,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             expired
);

  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/ddr4_init_sequencer.sv
// DDR4 power-up sequencer: reset_n low/high, CKE rise, MR3..MR0 writes, ZQCL,
// then init_done. All pin outputs are registered from the next-state decode.
module ddr4_init_sequencer
  import ddr_package::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_RESET_L = DEF_T_RESET_L,
  parameter int T_CKE_L   = DEF_T_CKE_L,
  parameter int T_XPR     = DEF_T_XPR,
  parameter int T_MRD     = DEF_T_MRD,
  parameter int T_MOD     = DEF_T_MOD,
  parameter int T_ZQ      = DEF_T_ZQ
) (
  input  logic        clock_t,
  input  logic        reset,
  input  logic        start,
  output logic [2:0]  mr_sel,
  input  logic [13:0] mr_value,
  output logic        reset_n,
  output logic        cke,
  output logic        cs_n,
  output logic        act_n,
  output logic        ras_n_a16,
  output logic        cas_n_a15,
  output logic        we_n_a14,
  output logic [1:0]  bg,
  output logic [1:0]  ba,
  output logic [13:0] addr,
  output logic        busy,
  output logic        init_done
);

  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  // Issue-to-issue delays include the issue cycle itself, and the MR select must
  // reach the host one cycle before the command is registered, hence >= 2.
  if (T_RESET_L < 1 || T_CKE_L < 1 || T_XPR < 1 ||
      T_MRD < 2 || T_MOD < 2 || T_ZQ < 2) begin : g_bad_delay
    $error("ddr4_init_sequencer: delay parameter out of range");
  end

  if (longint'(T_RESET_L) > CNT_SPAN || longint'(T_CKE_L) > CNT_SPAN ||
      longint'(T_XPR) > CNT_SPAN || longint'(T_MRD) > CNT_SPAN ||
      longint'(T_MOD) > CNT_SPAN || longint'(T_ZQ) > CNT_SPAN) begin : g_bad_width
    $error("ddr4_init_sequencer: delay parameter does not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_RESET_L = CNT_W'(T_RESET_L - 1);
  localparam logic [CNT_W-1:0] LD_CKE_L   = CNT_W'(T_CKE_L - 1);
  localparam logic [CNT_W-1:0] LD_XPR     = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] LD_MRD     = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_MOD     = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LD_ZQ      = CNT_W'(T_ZQ - 1);

  localparam logic [2:0] LAST_MRS_IDX = 3'(NUM_MRS - 1);
  localparam logic [2:0] MRS_DONE_IDX = 3'(NUM_MRS);

  init_state_t      state_q, state_d;
  logic [2:0]       mr_idx_q, mr_idx_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_value;
  logic [CNT_W-1:0] timer_count_unused;
  logic             timer_expired;

  logic [2:0]       mr_next;
  ddr_cmd_t         cmd_d;
  logic [1:0]       bg_d;
  logic [1:0]       ba_d;
  logic [13:0]      addr_d;

  init_delay_timer #(.CNT_W(CNT_W)) u_timer (
    .clock_t    (clock_t),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_count_unused),
    .expired    (timer_expired)
  );

  always_ff @(posedge clock_t) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      mr_idx_q <= mr_idx_d;
    end
  end

  // NOTE: every variable driven here gets a default before the case, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    mr_idx_d         = mr_idx_q;
    timer_load       = 1'b0;
    timer_load_value = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d          = ST_RST_LOW;
          mr_idx_d         = '0;
          timer_load       = 1'b1;
          timer_load_value = LD_RESET_L;
        end
      end
      ST_RST_LOW: begin
        if (timer_expired) begin
          state_d          = ST_RST_HIGH;
          timer_load       = 1'b1;
          timer_load_value = LD_CKE_L;
        end
      end
      ST_RST_HIGH: begin
        if (timer_expired) begin
          state_d          = ST_XPR_WAIT;
          timer_load       = 1'b1;
          timer_load_value = LD_XPR;
        end
      end
      ST_XPR_WAIT: begin
        if (timer_expired) begin
          state_d          = ST_MRS_ISSUE;
          timer_load       = 1'b1;
          timer_load_value = LD_MRD;
        end
      end
      ST_MRS_ISSUE: begin
        state_d  = ST_MRS_WAIT;
        mr_idx_d = mr_idx_q + 3'd1;
      end
      ST_MRS_WAIT: begin
        // The counter loaded at issue covers the issue cycle plus this wait.
        if (timer_expired) begin
          timer_load = 1'b1;
          if (mr_idx_q == MRS_DONE_IDX) begin
            state_d          = ST_ZQ_ISSUE;
            timer_load_value = LD_ZQ;
          end else begin
            state_d          = ST_MRS_ISSUE;
            timer_load_value = (mr_idx_q == LAST_MRS_IDX) ? LD_MOD : LD_MRD;
          end
        end
      end
      ST_ZQ_ISSUE: begin
        state_d = ST_ZQ_WAIT;
      end
      ST_ZQ_WAIT: begin
        if (timer_expired) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin values for the cycle after the edge; mr_value is captured at the edge
  // that starts the issue cycle, while mr_sel already shows that register.
  always_comb begin
    mr_next = mr_at(mr_idx_d);
    cmd_d   = CMD_DES;
    bg_d    = '0;
    ba_d    = '0;
    addr_d  = '0;

    case (state_d)
      ST_MRS_ISSUE: begin
        cmd_d  = CMD_MRS;
        bg_d   = {1'b0, mr_next[2]};
        ba_d   = mr_next[1:0];
        addr_d = mr_value;
      end
      ST_ZQ_ISSUE: begin
        cmd_d  = CMD_ZQCL;
        addr_d = ZQCL_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      reset_n   <= 1'b0;
      cke       <= 1'b0;
      {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} <= CMD_DES;
      bg        <= '0;
      ba        <= '0;
      addr      <= '0;
      mr_sel    <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      reset_n   <= !(state_d inside {ST_IDLE, ST_RST_LOW});
      cke       <= !(state_d inside {ST_IDLE, ST_RST_LOW, ST_RST_HIGH});
      {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} <= cmd_d;
      bg        <= bg_d;
      ba        <= ba_d;
      addr      <= addr_d;
      mr_sel    <= (state_d inside {ST_XPR_WAIT, ST_MRS_ISSUE, ST_MRS_WAIT}) ? mr_next : 3'd0;
      busy      <= !(state_d inside {ST_IDLE, ST_DONE});
      init_done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_ddr4_init_sequencer.sv
// Directed bench for ddr4_init_sequencer: checks event timing, MRS contents,
// start filtering, mid-sequence abort and restart from DONE at default timing.
module tb_ddr4_init_sequencer;

  logic        clock_t = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [2:0]  mr_sel;
  logic [13:0] mr_value;
  logic        reset_n, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
  logic [1:0]  bg, ba;
  logic [13:0] addr;
  logic        busy, init_done;

  ddr4_init_sequencer dut (
    .clock_t   (clock_t),
    .reset     (reset),
    .start     (start),
    .mr_sel    (mr_sel),
    .mr_value  (mr_value),
    .reset_n   (reset_n),
    .cke       (cke),
    .cs_n      (cs_n),
    .act_n     (act_n),
    .ras_n_a16 (ras_n_a16),
    .cas_n_a15 (cas_n_a15),
    .we_n_a14  (we_n_a14),
    .bg        (bg),
    .ba        (ba),
    .addr      (addr),
    .busy      (busy),
    .init_done (init_done)
  );

  always #5 clock_t = ~clock_t;

  // Host mode-register source: value tagged with the requested MR number.
  assign mr_value = 14'h1000 | {11'd0, mr_sel};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_mr [7] = '{3, 6, 5, 4, 2, 1, 0};

  int          rn_rise, cke_rise, zq_t, done_t, mrs_n, bad_cmd;
  int          mrs_t     [8];
  logic [13:0] mrs_addr  [8];
  logic [3:0]  mrs_bgba  [8];
  logic [2:0]  mrs_sel   [8];
  logic [13:0] zq_addr;
  logic [3:0]  zq_bgba;
  logic        c1_rn, c1_cke, c1_busy, c1_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_t);
    #1;
    cyc++;
  endtask

  function automatic logic [4:0] cmd_pins();
    return {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14};
  endfunction

  task automatic check_reset_values(input string p);
    check({p, " reset_n"},   32'(reset_n),    32'd0);
    check({p, " cke"},       32'(cke),        32'd0);
    check({p, " cmd"},       32'(cmd_pins()), 32'h1f);
    check({p, " bg"},        32'(bg),         32'd0);
    check({p, " ba"},        32'(ba),         32'd0);
    check({p, " addr"},      32'(addr),       32'd0);
    check({p, " mr_sel"},    32'(mr_sel),     32'd0);
    check({p, " busy"},      32'(busy),       32'd0);
    check({p, " init_done"}, 32'(init_done),  32'd0);
  endtask

  // Pulses start in cycle 0, optionally again in cycles pa/pb, and logs every
  // pin event for 160 cycles; cycle n is sampled 1 time unit after edge n.
  task automatic run_seq(input int pa, input int pb);
    logic prev_rn, prev_cke;
    logic [4:0] cmd;
    cyc = 0; rn_rise = -1; cke_rise = -1; zq_t = -1; done_t = -1;
    mrs_n = 0; bad_cmd = 0;
    for (int i = 0; i < 8; i++) begin
      mrs_t[i] = -1; mrs_addr[i] = '0; mrs_bgba[i] = '0; mrs_sel[i] = '0;
    end
    zq_addr = '1; zq_bgba = '1;
    prev_rn = reset_n; prev_cke = cke;
    start = 1'b1;
    while (cyc < 160) begin
      step();
      start = (cyc == pa) || (cyc == pb);
      cmd = cmd_pins();
      if (cyc == 1) begin
        c1_rn = reset_n; c1_cke = cke; c1_busy = busy; c1_done = init_done;
      end
      if (reset_n && !prev_rn && rn_rise < 0) rn_rise = cyc;
      if (cke && !prev_cke && cke_rise < 0) cke_rise = cyc;
      if (init_done && done_t < 0 && cyc > 1) done_t = cyc;
      if (cmd == 5'b01000) begin
        if (mrs_n < 8) begin
          mrs_t[mrs_n] = cyc; mrs_addr[mrs_n] = addr;
          mrs_bgba[mrs_n] = {bg, ba}; mrs_sel[mrs_n] = mr_sel;
        end
        mrs_n++;
      end else if (cmd == 5'b01110) begin
        if (zq_t < 0) begin
          zq_t = cyc; zq_addr = addr; zq_bgba = {bg, ba};
        end
      end else if (cmd != 5'b11111) begin
        bad_cmd++;
      end
      prev_rn = reset_n; prev_cke = cke;
    end
    start = 1'b0;
  endtask

  task automatic check_seq(input string p);
    check({p, " c1 reset_n"},   32'(c1_rn),   32'd0);
    check({p, " c1 cke"},       32'(c1_cke),  32'd0);
    check({p, " c1 busy"},      32'(c1_busy), 32'd1);
    check({p, " c1 init_done"}, 32'(c1_done), 32'd0);
    check({p, " reset_n rise"}, rn_rise,  32'd11);
    check({p, " cke rise"},     cke_rise, 32'd31);
    check({p, " mrs count"},    mrs_n,    32'd7);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s mrs%0d time", p, k),   mrs_t[k],          32'(39 + 8 * k));
      check($sformatf("%s mrs%0d addr", p, k),   32'(mrs_addr[k]),  32'(32'h1000 | exp_mr[k]));
      check($sformatf("%s mrs%0d bg_ba", p, k),  32'(mrs_bgba[k]),  32'(exp_mr[k]));
      check($sformatf("%s mrs%0d mr_sel", p, k), 32'(mrs_sel[k]),   32'(exp_mr[k]));
    end
    check({p, " zqcl time"},     zq_t,          32'd111);
    check({p, " zqcl addr"},     32'(zq_addr),  32'h0400);
    check({p, " zqcl bg_ba"},    32'(zq_bgba),  32'd0);
    check({p, " init_done time"}, done_t,       32'd143);
    check({p, " stray commands"}, bad_cmd,      32'd0);
  endtask

  initial begin
    logic [2:0] sel70;
    logic [4:0] cmd70;

    // Power-on reset.
    reset = 1'b1;
    repeat (3) step();
    check_reset_values("por");
    reset = 1'b0;
    step();
    check("idle busy", 32'(busy), 32'd0);

    // Scenario 1: full sequence from IDLE.
    run_seq(-1, -1);
    check_seq("run1");
    check("done init_done", 32'(init_done),  32'd1);
    check("done busy",      32'(busy),       32'd0);
    check("done reset_n",   32'(reset_n),    32'd1);
    check("done cke",       32'(cke),        32'd1);
    check("done cmd",       32'(cmd_pins()), 32'h1f);
    check("done mr_sel",    32'(mr_sel),     32'd0);

    // Scenario 2: restart from DONE with ignored start pulses at 50 and 60.
    run_seq(50, 60);
    check_seq("restart");

    // Scenario 3: reset in the middle of the MRS phase, then start at cycle 80.
    cyc = 0;
    start = 1'b1;
    while (cyc < 70) begin
      step();
      start = 1'b0;
    end
    sel70 = mr_sel;
    cmd70 = cmd_pins();
    check("abort c70 mr_sel", 32'(sel70), 32'd2);
    check("abort c70 cmd",    32'(cmd70), 32'h1f);
    reset = 1'b1;
    step();
    check_reset_values("abort c71");
    reset = 1'b0;
    while (cyc < 80) step();
    check("abort c80 busy",    32'(busy),    32'd0);
    check("abort c80 reset_n", 32'(reset_n), 32'd0);
    run_seq(-1, -1);
    check_seq("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
